// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN selects the 11-bit (even parity) frame.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE        = 3'd0,
    RX_START_CHECK = 3'd1,
    RX_DATA_BITS   = 3'd2,
    RX_PARITY_BIT  = 3'd3,
    RX_STOP_BIT    = 3'd4,
    RX_BREAK_WAIT  = 3'd5
  } rx_state_e;

  localparam logic [3:0] DATA_BITS = 4'd8;

`ifdef UART_RX_PARITY_EN
  localparam logic [3:0] FRAME_BITS = 4'd11;
`else
  localparam logic [3:0] FRAME_BITS = 4'd10;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus falling-edge detect on the
// synchronized line. All flops reset to the idle-high level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic uart_clock,
  input  logic uart_reset,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next-state for the synchronizer chain and edge history.
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and history flops.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_sync = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [23:0] baud_rate  = 24'd4000000,
  parameter logic [27:0] clock_freq = 28'd50000000
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic       uart_rx_in,
  output logic [7:0] uart_d_out,
  output logic       uart_rx_valid,
  output logic       uart_frame_err,
  output logic       uart_parity_err,
  output logic       uart_rx_busy
);

  localparam logic [23:0] BIT_CYCLES  = 24'(clock_freq / 28'(baud_rate) + 28'd1);
  localparam logic [23:0] HALF_CYCLES = BIT_CYCLES / 24'd2;

  logic rx_s;
  logic rx_fall_s;

  rx_state_e   state_q,     state_d;
  logic [23:0] clk_count_q, clk_count_d;
  logic [3:0]  bit_count_q, bit_count_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  d_out_q,     d_out_d;
  logic        valid_q,     valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q,      busy_d;
`ifdef UART_RX_PARITY_EN
  logic        parity_bad_q, parity_bad_d;
  logic        parity_err_q, parity_err_d;
`endif

  uart_rx_sync u_sync (
    .uart_clock (uart_clock),
    .uart_reset (uart_reset),
    .rx_in      (uart_rx_in),
    .rx_sync    (rx_s),
    .rx_fall    (rx_fall_s)
  );

  // Receive state machine: next state, counters and output strobes.
  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    d_out_d     = d_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        if (rx_fall_s) begin
          clk_count_d = 24'd0;
          state_d     = RX_START_CHECK;
        end else begin
          clk_count_d = clk_count_q;
        end
      end
      RX_START_CHECK: begin
        if (clk_count_q == HALF_CYCLES - 24'd1) begin
          clk_count_d = 24'd0;
          state_d     = rx_s ? RX_IDLE : RX_DATA_BITS;
        end else begin
          clk_count_d = clk_count_q + 24'd1;
        end
      end
      RX_DATA_BITS: begin
        if (clk_count_q == BIT_CYCLES - 24'd1) begin
          clk_count_d = 24'd0;
          shift_d     = {rx_s, shift_q[7:1]};
          bit_count_d = bit_count_q + 4'd1;
          if (bit_count_q == DATA_BITS - 4'd1) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY_BIT;
`else
            state_d = RX_STOP_BIT;
`endif
          end else begin
            state_d = RX_DATA_BITS;
          end
        end else begin
          clk_count_d = clk_count_q + 24'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY_BIT: begin
        if (clk_count_q == BIT_CYCLES - 24'd1) begin
          clk_count_d  = 24'd0;
          parity_bad_d = ^{shift_q, rx_s};
          state_d      = RX_STOP_BIT;
        end else begin
          clk_count_d = clk_count_q + 24'd1;
        end
      end
`endif
      RX_STOP_BIT: begin
        if (clk_count_q == BIT_CYCLES - 24'd1) begin
          clk_count_d = 24'd0;
          if (rx_s) begin
            state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              d_out_d = shift_q;
            end
`else
            valid_d = 1'b1;
            d_out_d = shift_q;
`endif
          end else begin
            // A low stop bit may be a break; wait for the line to recover.
            frame_err_d = 1'b1;
            state_d     = RX_BREAK_WAIT;
          end
        end else begin
          clk_count_d = clk_count_q + 24'd1;
        end
      end
      RX_BREAK_WAIT: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_BREAK_WAIT;
        end
      end
      default: begin
        state_d     = RX_IDLE;
        clk_count_d = 24'd0;
      end
    endcase
    bit_count_d = (state_d == RX_IDLE) ? 4'd0 : bit_count_d;
    busy_d      = (state_d != RX_IDLE);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state_q     <= RX_IDLE;
      clk_count_q <= 24'd0;
      bit_count_q <= 4'd0;
      shift_q     <= 8'h00;
      d_out_q     <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      d_out_q     <= d_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign uart_d_out     = d_out_q;
  assign uart_rx_valid  = valid_q;
  assign uart_frame_err = frame_err_q;
  assign uart_rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign uart_parity_err = parity_err_q;
`else
  assign uart_parity_err = 1'b0;
`endif

endmodule
